// File: rtl/serdes_tx_pkg.sv
// Purpose: shared types and constants for the SerDes transmit serializer.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package serdes_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PRBS  = 2'd2
  } state_t;

  localparam int          DEFAULT_DATA_W = 10;
  localparam logic [6:0]  PRBS7_SEED     = 7'h7F;
  localparam int          PRBS7_TAP_A    = 6;
  localparam int          PRBS7_TAP_B    = 5;

  // One step of the x^7+x^6+1 Fibonacci LFSR: shift left, feedback into LSB.
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// Purpose: PRBS7 bit source; output is the LFSR MSB, reseeded on load.
// Latency: bit_out is combinational; with load high it shows the seed MSB.
// Backpressure: none; advances only when load or en is high.
module prbs7_gen
  import serdes_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic bit_out
);

  logic [6:0] lfsr_q;
  logic [6:0] cur;

  // On load the seed itself is the current state, so its MSB goes out this cycle.
  assign cur     = load ? PRBS7_SEED : lfsr_q;
  assign bit_out = cur[6];

  // Advance the LFSR from the (possibly reseeded) current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= PRBS7_SEED;
    end else if (load || en) begin
      lfsr_q <= prbs7_step(cur);
    end
  end

endmodule

// File: rtl/tx_serializer.sv
// Purpose: parallel-to-serial TX, LSB first, idle pattern when empty; PRBS7 mode under `TX_PRBS_EN.
// Latency: bit 0 on tx_out one clock after accept; DATA_W cycles per word, no gap back-to-back.
// Backpressure: data_ready only in IDLE or on the last bit of a word; forced low in PRBS.
module tx_serializer
  import serdes_tx_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter bit IDLE_TOGGLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              prbs_sel,
  output logic              tx_out,
  output logic              word_start,
  output logic              busy
);

  localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                tog_q;
  logic                tx_q;
  logic                ws_q;
  logic                busy_q;

  logic last_bit;
  logic accept;
  logic idle_bit;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign idle_bit = IDLE_TOGGLE ? ~tog_q : 1'b0;

`ifdef TX_PRBS_EN
  logic prbs_pend_q;
  logic prbs_block;
  logic prbs_enter;
  logic prbs_bit;

  // A PRBS request seen during a word is remembered so the word finishes first.
  assign prbs_block = prbs_sel || prbs_pend_q;
  assign prbs_enter = ((state_q == IDLE) && prbs_sel) || (last_bit && prbs_block);
  assign data_ready = ((state_q == IDLE) && !prbs_sel) || (last_bit && !prbs_block);

  prbs7_gen u_prbs7 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (prbs_enter),
    .en      ((state_q == PRBS) && prbs_sel),
    .bit_out (prbs_bit)
  );
`else
  logic unused_prbs_sel;
  assign unused_prbs_sel = prbs_sel;
  assign data_ready      = (state_q == IDLE) || last_bit;
`endif

  assign accept = data_valid && data_ready;

  // Serializer FSM: load on accept, shift in SHIFT, idle pattern otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      tog_q   <= 1'b0;
      tx_q    <= 1'b0;
      ws_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TX_PRBS_EN
      prbs_pend_q <= 1'b0;
`endif
    end else begin
      ws_q <= 1'b0;
      if (accept) begin
        tx_q    <= data_in[0];
        shreg_q <= data_in >> 1;
        cnt_q   <= '0;
        ws_q    <= 1'b1;
        state_q <= SHIFT;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            if (!last_bit) begin
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
              cnt_q   <= cnt_q + 1'b1;
`ifdef TX_PRBS_EN
              if (prbs_sel) prbs_pend_q <= 1'b1;
`endif
            end else begin
              busy_q <= 1'b0;
`ifdef TX_PRBS_EN
              prbs_pend_q <= 1'b0;
              if (prbs_block) begin
                state_q <= PRBS;
                tx_q    <= prbs_bit;
              end else
`endif
              begin
                state_q <= IDLE;
                tx_q    <= idle_bit;
                if (IDLE_TOGGLE) tog_q <= ~tog_q;
              end
            end
          end
`ifdef TX_PRBS_EN
          PRBS: begin
            if (prbs_sel) begin
              tx_q <= prbs_bit;
            end else begin
              state_q <= IDLE;
              tx_q    <= idle_bit;
              if (IDLE_TOGGLE) tog_q <= ~tog_q;
            end
          end
`endif
          default: begin
            state_q <= IDLE;
`ifdef TX_PRBS_EN
            if (prbs_sel) begin
              state_q <= PRBS;
              tx_q    <= prbs_bit;
            end else
`endif
            begin
              tx_q <= idle_bit;
              if (IDLE_TOGGLE) tog_q <= ~tog_q;
            end
          end
        endcase
      end
    end
  end

  assign tx_out     = tx_q;
  assign word_start = ws_q;
  assign busy       = busy_q;

endmodule
